// File: rtl/inference_pkg.sv
// Shared types and helpers for the inference output stages.
// Contents:
//   NUM_LOGITS_DEF, TOKEN_W, COUNT_W : default sizing
//   fp16_t, token_t                  : logit and token types
//   argmax_state_e                   : argmax sequencer states
//   fp16_order_key()                 : fp16 -> unsigned-comparable key
//   fp16_is_nan()                    : fp16 NaN detector
package inference_pkg;

  localparam int NUM_LOGITS_DEF = 76;
  localparam int TOKEN_W        = 7;
  localparam int COUNT_W        = 12;

  typedef logic [15:0]        fp16_t;
  typedef logic [TOKEN_W-1:0] token_t;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } argmax_state_e;

  // Map an fp16 value onto an unsigned key with the same ordering:
  // negatives are bit-inverted so larger magnitude sorts lower, and
  // positives get the sign bit set so they sort above all negatives.
  // -0 (16'h8000) maps to 16'h7FFF, just below +0 at 16'h8000.
  function automatic fp16_t fp16_order_key(input fp16_t x);
    fp16_t key;
    if (x[15]) begin
      key = ~x;
    end else begin
      key = x ^ 16'h8000;
    end
    return key;
  endfunction

  // All-ones exponent with a non-zero mantissa.
  function automatic logic fp16_is_nan(input fp16_t x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

endpackage

// File: rtl/fp16_max_cmp.sv
// Combinational running-max step: keeps the best (key, index) pair, replacing
// it with the candidate only on a strictly greater key so that ties resolve to
// whichever was seen first (the lower index in a streaming scan).
// Ports:
//   cand_key/cand_idx : candidate ordering key and its index
//   best_key/best_idx : current best
//   new_key/new_idx   : updated best
module fp16_max_cmp
  import inference_pkg::*;
(
  input  fp16_t  cand_key,
  input  token_t cand_idx,
  input  fp16_t  best_key,
  input  token_t best_idx,
  output fp16_t  new_key,
  output token_t new_idx
);

  logic cand_wins_s;

  // Strict compare keeps the earlier entry on ties.
  always_comb begin
    cand_wins_s = (cand_key > best_key);
    if (cand_wins_s) begin
      new_key = cand_key;
      new_idx = cand_idx;
    end else begin
      new_key = best_key;
      new_idx = best_idx;
    end
  end

endmodule

// File: rtl/logit_argmax.sv
// Streaming argmax over fp16 logit frames with generation-length tracking.
// Consumes one logit per beat, presents the index of the largest logit as the
// next token, counts emitted tokens and flags completion on the end token or
// the length limit.
// Optional build macro: LOGIT_NAN_FILTER_EN -- when defined, NaN logits are
// excluded from the comparison and raise nan_seen; otherwise NaNs compare by
// ordering key and nan_seen stays 0.
// Ports:
//   clk, reset, clear               : clock, synchronous resets (identical effect)
//   logit_valid/data/last/ready     : logit beat stream in
//   token_valid/token/token_ready   : argmax token out
//   generate_count                  : tokens emitted since clear (saturates)
//   generate_complete               : end token or length limit reached
//   length_error                    : sticky, a frame was not NUM_LOGITS long
//   nan_seen                        : sticky, a NaN logit was filtered
module logit_argmax
  import inference_pkg::*;
#(
  parameter int           NUM_LOGITS = NUM_LOGITS_DEF,
  parameter token_t       END_TOKEN  = 7'd75,
  parameter logic [11:0]  MAX_TOKENS = 12'd2048
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         logit_valid,
  input  logic [15:0]  logit_data,
  input  logic         logit_last,
  output logic         logit_ready,
  output logic         token_valid,
  output logic [6:0]   token,
  input  logic         token_ready,
  output logic [11:0]  generate_count,
  output logic         generate_complete,
  output logic         length_error,
  output logic         nan_seen
);

  localparam token_t LAST_IDX = token_t'(NUM_LOGITS - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  argmax_state_e      state_q, state_d;
  token_t             idx_q, idx_d;
  logic               ovf_q, ovf_d;     // beat index has run past NUM_LOGITS-1
  logic               have_q, have_d;   // best holds a compared logit this frame
  fp16_t              best_key_q, best_key_d;
  token_t             best_idx_q, best_idx_d;
  token_t             token_q, token_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               logit_ready_q, logit_ready_d;
  logic               token_valid_q, token_valid_d;
  logic               complete_q, complete_d;
  logic               length_error_q, length_error_d;
  logic               nan_seen_q, nan_seen_d;

  fp16_t              key_s;
  fp16_t              cmp_key_s;
  token_t             cmp_idx_s;
  fp16_t              nb_key_s;
  token_t             nb_idx_s;
  logic               accept_s;
  logic               nan_s;
  logic               consider_s;
  logic [COUNT_W-1:0] count_inc_s;

  assign key_s = fp16_order_key(logit_data);

  fp16_max_cmp u_cmp (
    .cand_key (key_s),
    .cand_idx (idx_q),
    .best_key (best_key_q),
    .best_idx (best_idx_q),
    .new_key  (cmp_key_s),
    .new_idx  (cmp_idx_s)
  );

  // Beat classification: which beats take part in the comparison.
  always_comb begin
    accept_s = logit_valid && logit_ready_q;
`ifdef LOGIT_NAN_FILTER_EN
    nan_s = fp16_is_nan(logit_data);
`else
    nan_s = 1'b0;
`endif
    consider_s = !ovf_q && !nan_s;
  end

  // Best candidate after this beat, if it is accepted.
  always_comb begin
    nb_key_s = best_key_q;
    nb_idx_s = best_idx_q;
    if (consider_s) begin
      if (!have_q) begin
        nb_key_s = key_s;
        nb_idx_s = idx_q;
      end else begin
        nb_key_s = cmp_key_s;
        nb_idx_s = cmp_idx_s;
      end
    end else begin
      nb_key_s = best_key_q;
      nb_idx_s = best_idx_q;
    end
  end

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    ovf_d          = ovf_q;
    have_d         = have_q;
    best_key_d     = best_key_q;
    best_idx_d     = best_idx_q;
    token_d        = token_q;
    count_d        = count_q;
    logit_ready_d  = logit_ready_q;
    token_valid_d  = token_valid_q;
    complete_d     = complete_q;
    length_error_d = length_error_q;
    nan_seen_d     = nan_seen_q;
    count_inc_s    = (count_q == COUNT_MAX) ? count_q : (count_q + 12'd1);

    case (state_q)
      SCAN: begin
        if (accept_s) begin
          best_key_d = nb_key_s;
          best_idx_d = nb_idx_s;
          have_d     = have_q || consider_s;
          // Beats past the frame end are dropped and flagged.
          if (ovf_q) begin
            length_error_d = 1'b1;
          end else begin
            length_error_d = length_error_q;
          end
          if (nan_s) begin
            nan_seen_d = 1'b1;
          end else begin
            nan_seen_d = nan_seen_q;
          end
          // Index saturates; one more beat after the top index marks overflow.
          if (idx_q == LAST_IDX) begin
            ovf_d = ovf_q || !logit_last;
          end else begin
            idx_d = idx_q + 7'd1;
          end
          if (logit_last) begin
            if (ovf_q || (idx_q != LAST_IDX)) begin
              length_error_d = 1'b1;
            end else begin
              length_error_d = length_error_d;
            end
            state_d       = HOLD;
            token_d       = nb_idx_s;
            logit_ready_d = 1'b0;
            token_valid_d = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end else begin
          state_d = SCAN;
        end
      end
      HOLD: begin
        if (token_valid_q && token_ready) begin
          count_d       = count_inc_s;
          token_valid_d = 1'b0;
          if ((token_q == END_TOKEN) || (count_inc_s == MAX_TOKENS)) begin
            state_d    = DONE;
            complete_d = 1'b1;
          end else begin
            state_d       = SCAN;
            logit_ready_d = 1'b1;
            idx_d         = 7'd0;
            ovf_d         = 1'b0;
            have_d        = 1'b0;
            best_key_d    = 16'h0000;
            best_idx_d    = 7'd0;
          end
        end else begin
          state_d = HOLD;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d       = SCAN;
        logit_ready_d = 1'b1;
        token_valid_d = 1'b0;
        complete_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset and clear restore the same values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q        <= SCAN;
      idx_q          <= 7'd0;
      ovf_q          <= 1'b0;
      have_q         <= 1'b0;
      best_key_q     <= 16'h0000;
      best_idx_q     <= 7'd0;
      token_q        <= 7'd0;
      count_q        <= 12'd0;
      logit_ready_q  <= 1'b1;
      token_valid_q  <= 1'b0;
      complete_q     <= 1'b0;
      length_error_q <= 1'b0;
      nan_seen_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      ovf_q          <= ovf_d;
      have_q         <= have_d;
      best_key_q     <= best_key_d;
      best_idx_q     <= best_idx_d;
      token_q        <= token_d;
      count_q        <= count_d;
      logit_ready_q  <= logit_ready_d;
      token_valid_q  <= token_valid_d;
      complete_q     <= complete_d;
      length_error_q <= length_error_d;
      nan_seen_q     <= nan_seen_d;
    end
  end

  assign logit_ready       = logit_ready_q;
  assign token_valid       = token_valid_q;
  assign token             = token_q;
  assign generate_count    = count_q;
  assign generate_complete = complete_q;
  assign length_error      = length_error_q;
  assign nan_seen          = nan_seen_q;

endmodule

// File: tb/tb_logit_argmax.sv
// Directed self-checking bench for logit_argmax.
module tb_logit_argmax;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        logit_valid = 1'b0;
  logic [15:0] logit_data = 16'h0000;
  logic        logit_last = 1'b0;
  logic        logit_ready;
  logic        token_valid;
  logic [6:0]  token;
  logic        token_ready = 1'b0;
  logic [11:0] generate_count;
  logic        generate_complete;
  logic        length_error;
  logic        nan_seen;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  logic [15:0] frame_mem [0:79];

  always #5 clk = ~clk;

  logit_argmax dut (
    .clk               (clk),
    .reset             (reset),
    .clear             (clear),
    .logit_valid       (logit_valid),
    .logit_data        (logit_data),
    .logit_last        (logit_last),
    .logit_ready       (logit_ready),
    .token_valid       (token_valid),
    .token             (token),
    .token_ready       (token_ready),
    .generate_count    (generate_count),
    .generate_complete (generate_complete),
    .length_error      (length_error),
    .nan_seen          (nan_seen)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 80; i++) frame_mem[i] = v;
  endtask

  // Drives beats 0..last_idx; returns at posedge+1 after the last beat.
  task automatic send_frame(input int last_idx);
    for (int i = 0; i <= last_idx; i++) begin
      logit_valid = 1'b1;
      logit_data  = frame_mem[i];
      logit_last  = (i == last_idx);
      @(posedge clk); #1;
    end
    logit_valid = 1'b0;
    logit_last  = 1'b0;
  endtask

  task automatic take_token();
    token_ready = 1'b1;
    @(posedge clk); #1;
    token_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_count = 0;
  endtask

  // Frame, then check token and handshake, then transfer.
  task automatic frame_and_take(input string tag, input int last_idx, input logic [6:0] exp_tok);
    send_frame(last_idx);
    check({tag, "_valid"}, 16'(token_valid), 16'd1);
    check({tag, "_token"}, 16'(token), 16'(exp_tok));
    take_token();
    exp_count++;
    check({tag, "_count"}, 16'(generate_count), 16'(exp_count));
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst_ready", 16'(logit_ready), 16'd1);
    check("rst_tvalid", 16'(token_valid), 16'd0);
    check("rst_token", 16'(token), 16'd0);
    check("rst_count", 16'(generate_count), 16'd0);
    check("rst_complete", 16'(generate_complete), 16'd0);
    check("rst_lenerr", 16'(length_error), 16'd0);
    check("rst_nan", 16'(nan_seen), 16'd0);

    // All zeros: token 0, latency 1, then hold token_ready low for 5 cycles.
    fill(16'h0000);
    send_frame(75);
    check("zero_valid", 16'(token_valid), 16'd1);
    check("zero_token", 16'(token), 16'd0);
    check("zero_ready", 16'(logit_ready), 16'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_valid", 16'(token_valid), 16'd1);
      check("hold_token", 16'(token), 16'd0);
      check("hold_ready", 16'(logit_ready), 16'd0);
      check("hold_count", 16'(generate_count), 16'd0);
    end
    take_token();
    exp_count++;
    check("zero_count", 16'(generate_count), 16'(exp_count));
    check("zero_tvalid_off", 16'(token_valid), 16'd0);
    check("zero_ready_back", 16'(logit_ready), 16'd1);
    check("zero_lenerr", 16'(length_error), 16'd0);

    // 2.0 at 5, 3.0 at 40, 1.0 elsewhere.
    fill(16'h3C00);
    frame_mem[5]  = 16'h4000;
    frame_mem[40] = 16'h4200;
    frame_and_take("max40", 75, 7'd40);

    // Negatives: -0 at 20 is the largest.
    fill(16'hC000);
    frame_mem[10] = 16'hBC00;
    frame_mem[20] = 16'h8000;
    frame_and_take("negzero", 75, 7'd20);

    // Tie between 3 and 7 resolves to 3.
    fill(16'h0000);
    frame_mem[3] = 16'h4400;
    frame_mem[7] = 16'h4400;
    frame_and_take("tie", 75, 7'd3);
    check("tie_lenerr", 16'(length_error), 16'd0);

    // Short frame ending at beat 50: beat 50 still compared.
    fill(16'h0000);
    frame_mem[30] = 16'h3C00;
    frame_mem[50] = 16'h4000;
    frame_and_take("short", 50, 7'd50);
    check("short_lenerr", 16'(length_error), 16'd1);

    // Sticky flag survives a good frame.
    fill(16'h0000);
    frame_mem[60] = 16'h3C00;
    frame_and_take("sticky", 75, 7'd60);
    check("sticky_lenerr", 16'(length_error), 16'd1);

    do_clear();
    check("clr_count", 16'(generate_count), 16'd0);
    check("clr_lenerr", 16'(length_error), 16'd0);
    check("clr_ready", 16'(logit_ready), 16'd1);

    // Long frame: beats past 75 are ignored and flagged.
    fill(16'h0000);
    frame_mem[12] = 16'h3C00;
    frame_mem[76] = 16'h7BFF;
    frame_mem[77] = 16'h7BFF;
    frame_and_take("long", 77, 7'd12);
    check("long_lenerr", 16'(length_error), 16'd1);

    do_clear();
    // NaN at 2, 1.0 at 9.
    fill(16'h0000);
    frame_mem[2] = 16'h7E00;
    frame_mem[9] = 16'h3C00;
`ifdef LOGIT_NAN_FILTER_EN
    frame_and_take("nan", 75, 7'd9);
    check("nan_seen", 16'(nan_seen), 16'd1);
`else
    frame_and_take("nan", 75, 7'd2);
    check("nan_seen", 16'(nan_seen), 16'd0);
`endif
    check("nan_lenerr", 16'(length_error), 16'd0);

    // Mid-frame clear discards the partial frame.
    fill(16'h4000);
    for (int i = 0; i < 30; i++) begin
      logit_valid = 1'b1;
      logit_data  = frame_mem[i];
      logit_last  = 1'b0;
      @(posedge clk); #1;
    end
    logit_valid = 1'b0;
    do_clear();
    check("mid_count", 16'(generate_count), 16'd0);
    check("mid_tvalid", 16'(token_valid), 16'd0);
    fill(16'h0000);
    frame_mem[1] = 16'h3C00;
    frame_and_take("mid", 75, 7'd1);

    // End token: argmax at 75 finishes generation.
    fill(16'h0000);
    frame_mem[75] = 16'h3C00;
    frame_and_take("end", 75, 7'd75);
    check("end_complete", 16'(generate_complete), 16'd1);
    check("end_ready", 16'(logit_ready), 16'd0);
    check("end_tvalid", 16'(token_valid), 16'd0);

    // Beats in DONE are ignored and raise no error.
    logit_valid = 1'b1;
    logit_data  = 16'h3C00;
    logit_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    logit_valid = 1'b0;
    logit_last  = 1'b0;
    check("done_complete", 16'(generate_complete), 16'd1);
    check("done_lenerr", 16'(length_error), 16'd0);
    check("done_tvalid", 16'(token_valid), 16'd0);
    check("done_count", 16'(generate_count), 16'(exp_count));

    do_clear();
    check("clr2_count", 16'(generate_count), 16'd0);
    check("clr2_complete", 16'(generate_complete), 16'd0);
    check("clr2_ready", 16'(logit_ready), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logit_argmax.md
Name: logit_argmax

Overview:
- Sits directly downstream of the inference datapath.
- Consumes the stream of fp16 output logits, one per beat, for each generated position.
- Selects the index of the maximum logit and presents it as the next token.
- Tracks generation length and signals completion when the end token or the length limit is reached.

Parameters:
- NUM_LOGITS, 76, logits per frame (vocabulary size).
- END_TOKEN, 7'd75, token index that terminates generation.
- MAX_TOKENS, 12'd2048, generation length limit.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous start-of-sequence clear, same effect as reset.
- logit_valid  in  1  logit beat valid.
- logit_data  in  16  IEEE fp16 logit.
- logit_last  in  1  final beat of frame.
- logit_ready  out  1  block accepts a beat when high.
- token_valid  out  1  argmax token available.
- token  out  7  argmax index.
- token_ready  in  1  consumer accepts token.
- generate_count  out  12  tokens emitted since clear.
- generate_complete  out  1  generation finished.
- length_error  out  1  sticky; frame length was not NUM_LOGITS.
- nan_seen  out  1  sticky NaN flag (see Optional Feature).

Behaviour:
- Reset and clear are synchronous, active-high and identical in effect; reset has priority over clear, and clear has priority over everything else.
- Reset/clear values:
  - state = SCAN, beat index = 0, best key = 0, best index = 0.
  - logit_ready = 1, token_valid = 0, token = 0.
  - generate_count = 0, generate_complete = 0, length_error = 0, nan_seen = 0.
- A beat is accepted when logit_valid && logit_ready. A token transfers when token_valid && token_ready.
- Ordering key:
  - sign = 1: key = ~x.
  - sign = 0: key = x ^ 16'h8000.
  - Keys compare as unsigned. -0 orders below +0.
- SCAN state (logit_ready = 1):
  - The first accepted beat of a frame (index 0) loads best unconditionally.
  - Later beats replace best only if key > best key (strict). On ties the lowest index wins.
  - The beat index increments per accepted beat and saturates at NUM_LOGITS-1.
  - Beats at index >= NUM_LOGITS do not update best and set length_error.
  - A beat with logit_last moves the FSM to HOLD. If the index at last != NUM_LOGITS-1, set length_error.
- HOLD state (logit_ready = 0, token_valid = 1):
  - token = best index, asserted the cycle after the last beat is accepted (latency 1).
  - token and token_valid are held stable until token_ready.
  - On transfer, generate_count increments, saturating at 4095.
  - If token == END_TOKEN or the incremented count == MAX_TOKENS, go to DONE. Otherwise go to SCAN with index reset to 0.
- DONE state:
  - logit_ready = 0, token_valid = 0, generate_complete = 1.
  - Remains until clear or reset.
  - Beats presented in DONE are not accepted and are not an error.
- Sticky flags (length_error, nan_seen) persist across frames until clear or reset.
- Reset or clear mid-frame or mid-HOLD discards the partial frame and the pending token; the count is not incremented.

Optional Feature:
- Macro: LOGIT_NAN_FILTER_EN.
- Defined:
  - A logit with exponent 5'h1F and mantissa != 0 is excluded from the comparison and sets nan_seen.
  - If every logit of a frame is NaN, token = 0.
- Undefined:
  - NaNs compare by ordering key, so positive NaN beats +inf.
  - nan_seen is tied to 0.

Decomposition:
- Shared package inference_pkg:
  - NUM_LOGITS_DEF = 76, TOKEN_W = 7, COUNT_W = 12.
  - typedef fp16_t (logic [15:0]) and typedef token_t (logic [6:0]).
  - fp16 ordering-key function.
- Sub-module fp16_max_cmp (combinational): inputs candidate key/index and best key/index, outputs updated best. It is reused by later sampling stages.

Test Plan:
- All 76 logits 16'h0000, last on beat 75 -> token 0, token_valid one cycle after last, generate_count 1, length_error 0.
- Index 5 = 16'h4000 (2.0), index 40 = 16'h4200 (3.0), others 16'h3C00 -> token 40.
- All logits 16'hC000 (-2.0) except index 10 = 16'hBC00 (-1.0) and index 20 = 16'h8000 (-0) -> token 20.
- Index 3 and index 7 both 16'h4400 -> token 3 (tie goes to the lowest index).
- Hold token_ready low 5 cycles -> token stable, logit_ready 0, count unchanged until the transfer cycle.
- Argmax = 75 on frame 1 -> generate_complete 1, logit_ready 0; clear -> count 0, complete 0, SCAN.
- logit_last on beat 50 -> length_error 1, token from indices 0..50.
- With LOGIT_NAN_FILTER_EN, index 2 = 16'h7E00 and index 9 = 16'h3C00 -> token 9, nan_seen 1.
